// File: rtl/jac_sequencer.sv
// jac_sequencer: fetch/decode/execute controller for the Jac1-8 core.
// It owns R0..R3, the program counter and the latched status register, and it
// drives the combinational ALU. Each instruction takes FETCH, DECODE and EXEC.
// Optional macro SEQ_CALL_EN adds CALL (0x16) and RET (0x17) with a 1-deep
// return register. Without it, those opcodes are reserved and halt the core.
module jac_sequencer #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3,
  parameter int AddrWidth     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  output logic                     imem_en,
  output logic [AddrWidth-1:0]     imem_addr,
  input  logic [15:0]              imem_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [AddrWidth-1:0]     pc,
  output logic [NumStatusBits-1:0] status_q,
  output logic                     halted,
  output logic [DataWidth-1:0]     dbg_r0
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_NOT  = 5'h05;
  localparam logic [4:0] OP_XOR  = 5'h06;
  localparam logic [4:0] OP_SHL  = 5'h07;
  localparam logic [4:0] OP_SHR  = 5'h08;
  localparam logic [4:0] OP_VAL  = 5'h09;
  localparam logic [4:0] OP_GOTO = 5'h10;
  localparam logic [4:0] OP_IFZ  = 5'h11;
  localparam logic [4:0] OP_IFNZ = 5'h12;
  localparam logic [4:0] OP_IFEQ = 5'h13;
  localparam logic [4:0] OP_IFST = 5'h14;
  localparam logic [4:0] OP_IFGT = 5'h15;
`ifdef SEQ_CALL_EN
  localparam logic [4:0] OP_CALL = 5'h16;
  localparam logic [4:0] OP_RET  = 5'h17;
`endif

  state_t                   state_q, state_d;
  logic [15:0]              ir_q;
  logic [AddrWidth-1:0]     pc_q, pc_d, pc_inc;
  logic [DataWidth-1:0]     rf_q [4];
  logic [NumStatusBits-1:0] status_d;
  logic                     rf_we;
  logic [DataWidth-1:0]     rf_wdata;
  logic                     halt_op;
`ifdef SEQ_CALL_EN
  logic [AddrWidth-1:0]     ret_q, ret_d;
`endif

  logic [NumOpCodeBits-1:0] ir_op;
  logic [1:0]               ir_ra;
  logic [1:0]               ir_rb;
  logic [ParamBits-1:0]     ir_param;
  logic                     unused_ir_bit;

  assign ir_op         = ir_q[15:11];
  assign ir_ra         = ir_q[10:9];
  assign ir_rb         = ir_q[1:0];
  assign ir_param      = ir_q[7:0];
  assign unused_ir_bit = ir_q[8];

  assign pc_inc    = pc_q + AddrWidth'(1);
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign dbg_r0    = rf_q[0];

  // State register; reset wins in every state, including HALT.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: three cycles per instruction, and reserved opcodes trap in HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = halt_op ? S_HALT : (run ? S_FETCH : S_IDLE);
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs by state: memory enable in FETCH, ALU drive only in EXEC, idle values elsewhere.
  always_comb begin
    imem_en      = 1'b0;
    halted       = 1'b0;
    alu_opcode   = '0;
    alu_operand1 = '0;
    alu_operand2 = '0;
    alu_param    = '0;
    unique case (state_q)
      S_FETCH: imem_en = 1'b1;
      S_HALT:  halted = 1'b1;
      S_EXEC: begin
        alu_opcode   = ir_op;
        alu_operand1 = rf_q[ir_ra];
        alu_operand2 = rf_q[ir_rb];
        alu_param    = ir_param;
      end
      default: ;
    endcase
  end

  // Execute decode: work out the writeback, status, pc and call-return updates for the held instruction.
  always_comb begin
    pc_d     = pc_q;
    status_d = status_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    halt_op  = 1'b0;
`ifdef SEQ_CALL_EN
    ret_d    = ret_q;
`endif
    if (state_q == S_EXEC) begin
      case (ir_op)
        OP_NOP: pc_d = pc_inc;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL, OP_SHR: begin
          rf_we    = 1'b1;
          rf_wdata = alu_result;
          status_d = alu_status;
          pc_d     = pc_inc;
        end
        OP_VAL: begin
          rf_we    = 1'b1;
          rf_wdata = DataWidth'(ir_param);
          pc_d     = pc_inc;
        end
        OP_GOTO: pc_d = AddrWidth'(ir_param);
        OP_IFZ:  pc_d = status_q[2] ? AddrWidth'(ir_param) : pc_inc;
        OP_IFNZ: pc_d = !status_q[2] ? AddrWidth'(ir_param) : pc_inc;
        OP_IFEQ: pc_d = status_q[2] ? AddrWidth'(ir_param) : pc_inc;
        OP_IFST: pc_d = status_q[1] ? AddrWidth'(ir_param) : pc_inc;
        OP_IFGT: pc_d = (!status_q[2] && !status_q[1]) ? AddrWidth'(ir_param) : pc_inc;
`ifdef SEQ_CALL_EN
        OP_CALL: begin
          ret_d = pc_inc;
          pc_d  = AddrWidth'(ir_param);
        end
        OP_RET: pc_d = ret_q;
`endif
        default: halt_op = 1'b1;
      endcase
    end
  end

  // Architectural state: instruction latch in DECODE, and all writeback happens at the end of EXEC.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      status_q <= '0;
      ir_q     <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
`ifdef SEQ_CALL_EN
      ret_q    <= '0;
`endif
    end else begin
      pc_q     <= pc_d;
      status_q <= status_d;
      if (state_q == S_DECODE) ir_q <= imem_data;
      if (rf_we) rf_q[ir_ra] <= rf_wdata;
`ifdef SEQ_CALL_EN
      ret_q    <= ret_d;
`endif
    end
  end

endmodule
